// File: rtl/serial_flow_alu.sv
// Bit-serial adder/subtractor: two LSB-first operand streams in, one LSB-first
// result stream out one cycle later, with an overflow flag on the MSB beat.
module serial_flow_alu #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                     CK,
  input  logic                     RSTN,
  input  logic                     LINE1,
  input  logic                     LINE2,
  input  logic                     IN_VALID,
  input  logic                     SUB,
  input  logic                     ABORT,
  output logic                     OUTP,
  output logic                     OUT_VALID,
  output logic                     FRAME_END,
  output logic                     OVERFLW,
  output logic [$clog2(WIDTH)-1:0] BIT_IDX
);

  localparam int unsigned       IW   = $clog2(WIDTH);
  localparam logic [IW-1:0]     LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [IW-1:0] cnt;
  logic          carry;
  logic          op;

  logic          first, accept, op_eff, cin, b_eff, sum, cout, last, ovf;
  logic [IW-1:0] cnt_eff;

  // In IDLE the beat is bit 0: SUB drives both the B inversion and the carry-in.
  always_comb begin
    first   = (state == IDLE);
    accept  = IN_VALID & ~ABORT;
    op_eff  = first ? SUB : op;
    cin     = first ? SUB : carry;
    cnt_eff = first ? '0 : cnt;
    b_eff   = LINE2 ^ op_eff;
    sum     = LINE1 ^ b_eff ^ cin;
    cout    = (LINE1 & b_eff) | (LINE1 & cin) | (b_eff & cin);
    last    = (cnt_eff == LAST);
    ovf     = SIGNED ? (cin ^ cout) : (op_eff ? ~cout : cout);
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      op        <= 1'b0;
      OUTP      <= 1'b0;
      OUT_VALID <= 1'b0;
      FRAME_END <= 1'b0;
      OVERFLW   <= 1'b0;
      BIT_IDX   <= '0;
    end else begin
      OUT_VALID <= accept;
      FRAME_END <= accept & last;
      OVERFLW   <= accept & last & ovf;
      if (accept) begin
        OUTP    <= sum;
        BIT_IDX <= cnt_eff;
      end
      if (ABORT) begin
        state <= IDLE;
        cnt   <= '0;
        carry <= 1'b0;
      end else if (IN_VALID) begin
        op <= op_eff;
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
          carry <= 1'b0;
        end else begin
          state <= RUN;
          cnt   <= cnt_eff + IW'(1);
          carry <= cout;
        end
      end
    end
  end

endmodule
